// File: rtl/pong_mode_ctrl_if.sv
// Key, frame-timing and mode signals exchanged between the board/timing side
// (master) and the display mode controller (slave).
interface pong_mode_ctrl_if;
    logic       btn_start_n;
    logic       btn_pause_n;
    logic       frame_start;
    logic       game_over;
    logic       enablePong;
    logic       game_rst;
    logic       game_run;
    logic       blink;
    logic [2:0] state;

    modport master (
        output btn_start_n, btn_pause_n, frame_start, game_over,
        input  enablePong, game_rst, game_run, blink, state
    );

    modport slave (
        input  btn_start_n, btn_pause_n, frame_start, game_over,
        output enablePong, game_rst, game_run, blink, state
    );
endinterface

// File: rtl/pong_mode_ctrl.sv
// Menu/game mode sequencer: debounces start and pause keys, steps the
// MENU/ARM/LAUNCH/PLAY/PAUSE/OVER machine on frame boundaries, and produces
// the game reset pulse, motion enable and menu blink enable.
module pong_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned OVER_FRAMES     = 120
) (
    input logic             clk_in,
    input logic             i_rst_n,
    pong_mode_ctrl_if.slave bus
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BlW = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned OvW = $clog2(OVER_FRAMES + 1);

    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BlW-1:0] BlLast = BlW'(BLINK_FRAMES - 1);
    localparam logic [OvW-1:0] OvLast = OvW'(OVER_FRAMES - 1);

    localparam int unsigned KeyStart = 0;
    localparam int unsigned KeyPause = 1;

    typedef enum logic [2:0] {
        StMenu   = 3'd0,
        StArm    = 3'd1,
        StLaunch = 3'd2,
        StPlay   = 3'd3,
        StPause  = 3'd4,
        StOver   = 3'd5
    } state_e;

    // Key bit 0 is start, bit 1 is pause; all key levels are active-low.
    logic [1:0]     w_raw_n;
    logic [1:0]     r_sync1_n;
    logic [1:0]     r_sync2_n;
    logic [1:0]     r_deb_n;
    logic [DbW-1:0] r_db_cnt [2];
    logic [1:0]     w_press;

    state_e         w_state_nxt;
    state_e         r_state;
    logic [OvW-1:0] r_over_cnt;
    logic [BlW-1:0] r_blink_cnt;
    logic           r_enable_pong;
    logic           r_game_rst;
    logic           r_game_run;
    logic           r_blink;

    assign w_raw_n = {bus.btn_pause_n, bus.btn_start_n};

    // Two-flop synchronizer for the asynchronous key inputs, idle high.
    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1_n <= 2'b11;
            r_sync2_n <= 2'b11;
        end else begin
            r_sync1_n <= w_raw_n;
            r_sync2_n <= r_sync1_n;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deb_n <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_sync2_n[k] == r_deb_n[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DbLast) begin
                    r_deb_n[k]  <= r_sync2_n[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DbW'(1);
                end
            end
        end
    end

    // Press event: the debounced level is about to fall on this edge.
    always_comb begin
        w_press = '0;
        for (int k = 0; k < 2; k++) begin
            w_press[k] = (r_sync2_n[k] != r_deb_n[k]) && (r_db_cnt[k] == DbLast) &&
                         !r_sync2_n[k];
        end
    end

    // Mode transitions; events not relevant to the current state are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StMenu: begin
                if (w_press[KeyStart]) begin
                    w_state_nxt = StArm;
                end
            end
            StArm: begin
                if (bus.frame_start) begin
                    w_state_nxt = StLaunch;
                end
            end
            StLaunch: begin
                w_state_nxt = StPlay;
            end
            StPlay: begin
                // game_over wins over a coincident pause press
                if (bus.game_over) begin
                    w_state_nxt = StOver;
                end else if (w_press[KeyPause]) begin
                    w_state_nxt = StPause;
                end
            end
            StPause: begin
                if (w_press[KeyPause]) begin
                    w_state_nxt = StPlay;
                end
            end
            StOver: begin
                if (bus.frame_start && (r_over_cnt == OvLast)) begin
                    w_state_nxt = StMenu;
                end
            end
            default: begin
                w_state_nxt = StMenu;
            end
        endcase
    end

    // State register, game-over frame counter and mode outputs decoded from the next state.
    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StMenu;
            r_over_cnt    <= '0;
            r_enable_pong <= 1'b0;
            r_game_rst    <= 1'b0;
            r_game_run    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_enable_pong <= (w_state_nxt inside {StLaunch, StPlay, StPause, StOver});
            r_game_rst    <= (w_state_nxt == StLaunch);
            r_game_run    <= (w_state_nxt == StPlay);
            if (w_state_nxt != StOver) begin
                r_over_cnt <= '0;
            end else if ((r_state == StOver) && bus.frame_start) begin
                r_over_cnt <= r_over_cnt + OvW'(1);
            end
        end
    end

    // Menu blink: toggle every BLINK_FRAMES frames while staying in MENU, solid otherwise.
    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (w_state_nxt != StMenu) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if ((r_state == StMenu) && bus.frame_start) begin
            if (r_blink_cnt == BlLast) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + BlW'(1);
            end
        end
    end

    assign bus.enablePong = r_enable_pong;
    assign bus.game_rst   = r_game_rst;
    assign bus.game_run   = r_game_run;
    assign bus.blink      = r_blink;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_pong_mode_ctrl.sv
// Bench for pong_mode_ctrl: directed scenarios followed by random key and
// game_over traffic, all checked every cycle against a behavioural model.
module tb_pong_mode_ctrl;

    localparam int Deb         = 4;
    localparam int Blk         = 2;
    localparam int Ovr         = 3;
    localparam int FramePeriod = 20;

    localparam int MENU   = 0;
    localparam int ARM    = 1;
    localparam int LAUNCH = 2;
    localparam int PLAY   = 3;
    localparam int PAUSE  = 4;
    localparam int OVER   = 5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pong_mode_ctrl_if bus ();

    pong_mode_ctrl #(
        .DEBOUNCE_CYCLES (Deb),
        .BLINK_FRAMES    (Blk),
        .OVER_FRAMES     (Ovr)
    ) u_dut (
        .clk_in  (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int phase = 0;

    // Behavioural model: key delay line, debounced level, run length of a differing level.
    bit m_pipe [2][2];
    bit m_deb  [2];
    int m_run  [2];
    int m_state;
    int m_menu_frames;
    int m_over_frames;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pipe[k][0] = 1'b1;
            m_pipe[k][1] = 1'b1;
            m_deb[k]     = 1'b1;
            m_run[k]     = 0;
        end
        m_state       = MENU;
        m_menu_frames = 0;
        m_over_frames = 0;
    endtask

    // True when the next clock edge will accept a press of key k.
    function automatic bit will_press(input int k);
        return (m_pipe[k][1] != m_deb[k]) && (m_run[k] + 1 == Deb) && (m_pipe[k][1] == 1'b0);
    endfunction

    task automatic model_step();
        bit raw   [2];
        bit press [2];
        bit lvl;
        int nxt;
        raw[0] = bus.btn_start_n;
        raw[1] = bus.btn_pause_n;
        for (int k = 0; k < 2; k++) begin
            lvl      = m_pipe[k][1];
            press[k] = 1'b0;
            m_run[k] = (lvl != m_deb[k]) ? m_run[k] + 1 : 0;
            if (m_run[k] == Deb) begin
                m_deb[k] = lvl;
                m_run[k] = 0;
                press[k] = (lvl == 1'b0);
            end
            m_pipe[k][1] = m_pipe[k][0];
            m_pipe[k][0] = raw[k];
        end
        nxt = m_state;
        case (m_state)
            MENU:   if (press[0]) nxt = ARM;
            ARM:    if (bus.frame_start) nxt = LAUNCH;
            LAUNCH: nxt = PLAY;
            PLAY: begin
                if (bus.game_over) nxt = OVER;
                else if (press[1]) nxt = PAUSE;
            end
            PAUSE:  if (press[1]) nxt = PLAY;
            OVER: begin
                if (bus.frame_start) begin
                    m_over_frames++;
                    if (m_over_frames == Ovr) begin
                        nxt           = MENU;
                        m_over_frames = 0;
                    end
                end
            end
            default: nxt = MENU;
        endcase
        if (nxt != MENU) m_menu_frames = 0;
        else if (m_state == MENU && bus.frame_start) m_menu_frames++;
        m_state = nxt;
    endtask

    task automatic compare_all();
        check_eq("state", bus.state, m_state);
        check_eq("enablePong", bus.enablePong, m_state inside {LAUNCH, PLAY, PAUSE, OVER});
        check_eq("game_rst", bus.game_rst, m_state == LAUNCH);
        check_eq("game_run", bus.game_run, m_state == PLAY);
        check_eq("blink", bus.blink, (m_state != MENU) || ((m_menu_frames / Blk) % 2 == 0));
    endtask

    // One clock: drive frame_start, take the edge, advance the model, check on the falling edge.
    task automatic tick();
        bus.frame_start = (phase == FramePeriod - 1);
        phase = (phase + 1) % FramePeriod;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        bus.btn_start_n = 1'b1;
        bus.btn_pause_n = 1'b1;
        bus.frame_start = 1'b0;
        bus.game_over   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        phase = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (m_state != target && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, bus.state, target);
    endtask

    int         toggles;
    int         n_rst;
    int         edge_at;
    int         changes;
    int         hold_s;
    int         hold_p;
    bit         hit;
    logic       prev_blink;
    logic [2:0] prev_state;

    initial begin
        apply_reset();

        // Idle blink: six frames give three toggles.
        toggles    = 0;
        prev_blink = bus.blink;
        repeat (6 * FramePeriod) begin
            tick();
            if (bus.blink !== prev_blink) toggles++;
            prev_blink = bus.blink;
        end
        check_eq("blink_toggles", toggles, 3);

        // Short start glitch is ignored.
        n_rst = 0;
        bus.btn_start_n = 1'b0;
        repeat (3) tick();
        bus.btn_start_n = 1'b1;
        repeat (30) begin
            tick();
            if (bus.game_rst === 1'b1) n_rst++;
        end
        check_eq("glitch_rst", n_rst, 0);
        check_eq("glitch_state", bus.state, MENU);

        // Start press: ARM at edge 6, then a single launch pulse into PLAY.
        n_rst   = 0;
        edge_at = 0;
        bus.btn_start_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.game_rst === 1'b1) n_rst++;
            if (edge_at == 0 && bus.state === 3'(ARM)) begin
                edge_at = i;
                check_eq("arm_blink", bus.blink, 1);
            end
            if (i == 10) bus.btn_start_n = 1'b1;
        end
        check_eq("arm_edge", edge_at, 6);
        for (int i = 0; i < 60 && m_state != PLAY; i++) begin
            tick();
            if (bus.game_rst === 1'b1) n_rst++;
        end
        check_eq("launch_pulses", n_rst, 1);
        check_eq("play_state", bus.state, PLAY);

        // Pause held 100 cycles: exactly one state change.
        changes    = 0;
        prev_state = bus.state;
        bus.btn_pause_n = 1'b0;
        repeat (100) begin
            tick();
            if (bus.state !== prev_state) changes++;
            prev_state = bus.state;
        end
        bus.btn_pause_n = 1'b1;
        repeat (10) tick();
        check_eq("hold_toggles", changes, 1);
        check_eq("pause_state", bus.state, PAUSE);
        check_eq("pause_run", bus.game_run, 0);
        check_eq("pause_en", bus.enablePong, 1);

        // game_over while paused is ignored.
        bus.game_over = 1'b1;
        tick();
        bus.game_over = 1'b0;
        check_eq("pause_go_ignored", bus.state, PAUSE);

        // Second pause press resumes play.
        bus.btn_pause_n = 1'b0;
        repeat (8) tick();
        bus.btn_pause_n = 1'b1;
        repeat (8) tick();
        check_eq("resume_state", bus.state, PLAY);

        // game_over on the same edge as a pause press goes to OVER.
        hit = 1'b0;
        bus.btn_pause_n = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (will_press(1)) begin
                bus.game_over = 1'b1;
                hit = 1'b1;
            end
            tick();
            bus.game_over = 1'b0;
        end
        bus.btn_pause_n = 1'b1;
        check_eq("go_state", bus.state, OVER);
        run_until(MENU, 100, "over_exit");
        check_eq("over_exit_en", bus.enablePong, 0);

        // Asynchronous reset in the middle of PLAY.
        bus.btn_start_n = 1'b0;
        repeat (10) tick();
        bus.btn_start_n = 1'b1;
        run_until(PLAY, 60, "replay_state");
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_en", bus.enablePong, 0);
        check_eq("arst_run", bus.game_run, 0);
        check_eq("arst_blink", bus.blink, 1);
        check_eq("arst_rst", bus.game_rst, 0);
        apply_reset();

        // Random key and game_over traffic.
        hold_s = 0;
        hold_p = 0;
        repeat (2500) begin
            if (hold_s == 0) begin
                bus.btn_start_n = 1'($urandom_range(0, 1));
                hold_s = $urandom_range(1, 12);
            end else begin
                hold_s--;
            end
            if (hold_p == 0) begin
                bus.btn_pause_n = 1'($urandom_range(0, 1));
                hold_p = $urandom_range(1, 12);
            end else begin
                hold_p--;
            end
            bus.game_over = ($urandom_range(0, 39) == 0);
            tick();
        end
        bus.game_over = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
